// File: rtl/stim_seq.sv
// Handshaked stimulus sequencer: emits num_vec LFSR-derived vectors over a
// valid/ready interface, then pulses done. WIDTH must be even and >= 22.
module stim_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] ye_o,
  output logic [WIDTH-1:0] f_o,
  output logic [3:0]       abcd_o,
  output logic [3:0]       zysd_o,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] lfsr;
  logic [CNT_W-1:0] num_lat;

  logic             xfer;
  logic [WIDTH-1:0] lfsr_nxt;
  logic [WIDTH-1:0] seed_eff;
  logic [CNT_W-1:0] cnt_nxt;
  logic             last_xfer;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], v[WIDTH-1] ^ v[21] ^ v[1] ^ v[0]};
  endfunction

  function automatic logic [WIDTH-1:0] swap_halves(input logic [WIDTH-1:0] v);
    return {v[WIDTH/2-1:0], v[WIDTH-1:WIDTH/2]};
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  assign seed_eff  = (seed == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : seed;
  assign xfer      = (state == RUN) && valid && ready;
  assign lfsr_nxt  = lfsr_step(lfsr);
  assign cnt_nxt   = vec_cnt + 1'b1;
  assign last_xfer = xfer && (cnt_nxt == num_lat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lfsr    <= '0;
      num_lat <= '0;
      vec_cnt <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ye_o    <= '0;
      f_o     <= '0;
      abcd_o  <= '0;
      zysd_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            vec_cnt <= '0;
            zysd_o  <= '0;
            if (num_vec != '0) begin
              state   <= RUN;
              lfsr    <= seed_eff;
              num_lat <= num_vec;
              valid   <= 1'b1;
              busy    <= 1'b1;
              ye_o    <= seed_eff;
              f_o     <= swap_halves(seed_eff);
              abcd_o  <= seed_eff[3:0];
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        RUN: begin
          // A transfer is always counted, even when abort wins the state change.
          if (xfer) begin
            lfsr    <= lfsr_nxt;
            vec_cnt <= cnt_nxt;
            ye_o    <= lfsr_nxt;
            f_o     <= swap_halves(lfsr_nxt);
            abcd_o  <= lfsr_nxt[3:0];
            zysd_o  <= cnt_nxt[3:0];
          end
          if (abort) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (last_xfer) begin
            state <= DONE;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stim_seq.sv
// Directed bench for stim_seq: hand-computed LFSR vectors, stalls, zero-length,
// abort and asynchronous reset scenarios.
module tb_stim_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] seed;
  logic [15:0] num_vec;
  logic        ready;
  logic        valid;
  logic [31:0] ye_o;
  logic [31:0] f_o;
  logic [3:0]  abcd_o;
  logic [3:0]  zysd_o;
  logic        busy;
  logic        done;
  logic [15:0] vec_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  stim_seq #(.WIDTH(32), .CNT_W(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .seed   (seed),
    .num_vec(num_vec),
    .ready  (ready),
    .valid  (valid),
    .ye_o   (ye_o),
    .f_o    (f_o),
    .abcd_o (abcd_o),
    .zysd_o (zysd_o),
    .busy   (busy),
    .done   (done),
    .vec_cnt(vec_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // seed=1, num_vec=3, ready high: vectors 0x1, 0x3, 0x6 then done.
  task automatic run_seq3(input string pfx);
    seed = 32'h1; num_vec = 16'd3; ready = 1'b1; abort = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check({pfx, " v0 valid"}, valid, 1);
    check({pfx, " v0 busy"}, busy, 1);
    check({pfx, " v0 ye"}, ye_o, 32'h1);
    check({pfx, " v0 f"}, f_o, 32'h0001_0000);
    check({pfx, " v0 abcd"}, abcd_o, 4'h1);
    check({pfx, " v0 zysd"}, zysd_o, 4'h0);
    tick();
    check({pfx, " v1 ye"}, ye_o, 32'h3);
    check({pfx, " v1 f"}, f_o, 32'h0003_0000);
    check({pfx, " v1 zysd"}, zysd_o, 4'h1);
    check({pfx, " v1 valid"}, valid, 1);
    tick();
    check({pfx, " v2 ye"}, ye_o, 32'h6);
    check({pfx, " v2 f"}, f_o, 32'h0006_0000);
    check({pfx, " v2 abcd"}, abcd_o, 4'h6);
    check({pfx, " v2 zysd"}, zysd_o, 4'h2);
    check({pfx, " v2 valid"}, valid, 1);
    check({pfx, " v2 done"}, done, 0);
    tick();
    check({pfx, " end valid"}, valid, 0);
    check({pfx, " end done"}, done, 1);
    check({pfx, " end busy"}, busy, 0);
    check({pfx, " end cnt"}, vec_cnt, 16'd3);
    tick();
    check({pfx, " post done"}, done, 0);
    check({pfx, " post cnt"}, vec_cnt, 16'd3);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    seed = '0; num_vec = '0; ready = 1'b0;

    #12;
    check("rst valid", valid, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst ye", ye_o, 0);
    check("rst f", f_o, 0);
    check("rst cnt", vec_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Basic full-throughput sequence.
    run_seq3("seq3");

    // Zero seed, stalled consumer, inputs changed after capture.
    seed = 32'h0; num_vec = 16'd1; ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    seed = 32'hDEAD_BEEF; num_vec = 16'd7;
    for (int i = 0; i < 5; i++) begin
      check("stall valid", valid, 1);
      check("stall ye", ye_o, 32'h1);
      check("stall zysd", zysd_o, 4'h0);
      tick();
    end
    ready = 1'b1;
    tick();
    check("stall end valid", valid, 0);
    check("stall end done", done, 1);
    check("stall end cnt", vec_cnt, 16'd1);
    tick();
    check("stall post done", done, 0);

    // Zero-length sequence.
    num_vec = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero done", done, 1);
    check("zero valid", valid, 0);
    check("zero busy", busy, 0);
    check("zero cnt", vec_cnt, 16'd0);
    tick();
    check("zero post done", done, 0);
    check("zero post valid", valid, 0);

    // Abort after the 4th transfer, with a second start held during RUN.
    seed = 32'h1; num_vec = 16'd10; ready = 1'b1; start = 1'b1;
    tick();
    num_vec = 16'd0; seed = 32'h55;
    tick(); tick(); tick(); tick();
    start = 1'b0;
    check("abort pre busy", busy, 1);
    check("abort pre cnt", vec_cnt, 16'd4);
    check("abort pre ye", ye_o, 32'h1B);
    check("abort pre zysd", zysd_o, 4'h4);
    ready = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort valid", valid, 0);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort cnt", vec_cnt, 16'd4);
    tick();
    check("abort post done", done, 0);
    check("abort post cnt", vec_cnt, 16'd4);

    // Abort coincident with the final transfer: counted, but no done.
    seed = 32'h1; num_vec = 16'd2; ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("abxf mid cnt", vec_cnt, 16'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abxf cnt", vec_cnt, 16'd2);
    check("abxf done", done, 0);
    check("abxf valid", valid, 0);
    check("abxf busy", busy, 0);
    tick();
    check("abxf post done", done, 0);

    // Asynchronous reset mid-RUN, then restart.
    seed = 32'h1; num_vec = 16'd3; ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("arst pre busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst valid", valid, 0);
    check("arst busy", busy, 0);
    check("arst done", done, 0);
    check("arst ye", ye_o, 0);
    check("arst f", f_o, 0);
    check("arst abcd", abcd_o, 0);
    check("arst zysd", zysd_o, 0);
    check("arst cnt", vec_cnt, 0);
    tick();
    check("arst held done", done, 0);
    rst_n = 1'b1;
    tick();
    run_seq3("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/stim_seq.md
STIM_SEQ -- requirements
Module: stim_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the stimulus word width of ye_o/f_o and the LFSR.
REQ-002 SHALL have parameter CNT_W, default 16, the width of num_vec and vec_cnt.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, sequence-start request, sampled in IDLE only.
REQ-006 SHALL have port abort, input, 1, synchronous sequence cancel.
REQ-007 SHALL have port seed, input, WIDTH, LFSR seed captured on accepted start.
REQ-008 SHALL have port num_vec, input, CNT_W, vector count captured on accepted start.
REQ-009 SHALL have port ready, input, 1, downstream consumer accepts the current vector.
REQ-010 SHALL have port valid, output, 1, current vector is valid.
REQ-011 SHALL have port ye_o, output, WIDTH, stimulus word A.
REQ-012 SHALL have port f_o, output, WIDTH, stimulus word B.
REQ-013 SHALL have port abcd_o, output, 4, single-bit stimuli {a,b,c,d}.
REQ-014 SHALL have port zysd_o, output, 4, single-bit stimuli {zz,yy,ss,dd}.
REQ-015 SHALL have port busy, output, 1, high in RUN.
REQ-016 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-017 SHALL have port vec_cnt, output, CNT_W, number of vectors transferred in the current or last sequence.

Function
REQ-018 SHALL implement FSM states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-019 IDLE with start=1 and num_vec!=0: SHALL load lfsr<=seed (0 replaced by 1), latch num_vec, clear vec_cnt, go RUN, and assert valid on the next cycle.
REQ-020 IDLE with start=1 and num_vec==0: SHALL go DONE with no valid asserted.
REQ-021 LFSR step SHALL be next = {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]} for WIDTH=32.
REQ-022 Vector contents:
- ye_o = lfsr
- f_o = {lfsr[15:0], lfsr[31:16]}
- abcd_o = lfsr[3:0]
- zysd_o = vec_cnt[3:0]
REQ-023 A transfer SHALL occur on a cycle with valid=1 and ready=1; on transfer, lfsr advances one step and vec_cnt increments.
REQ-024 While valid=1 and ready=0, ye_o, f_o, abcd_o and zysd_o SHALL hold stable.
REQ-025 With ready held high, one transfer SHALL occur per cycle (full throughput).
REQ-026 On the transfer that makes vec_cnt equal the latched num_vec, SHALL deassert valid and go DONE in the same edge.
REQ-027 DONE SHALL last exactly one cycle with done=1, then return to IDLE; vec_cnt SHALL hold its final value until the next accepted start.
REQ-028 start SHALL be ignored in RUN and DONE; changes to seed and num_vec after capture SHALL have no effect.
REQ-029 abort=1 in RUN SHALL force IDLE on the next edge with valid=0 and done=0, leaving vec_cnt at its partial value.
REQ-030 abort=1 SHALL take priority over a simultaneous transfer: the vector is counted but no DONE occurs.
REQ-031 busy SHALL equal (state==RUN).

Reset
REQ-032 rst_n low SHALL immediately, without waiting for clk, force state IDLE and set valid, busy, done, ye_o, f_o, abcd_o, zysd_o, vec_cnt and lfsr to 0.
REQ-033 Reset asserted mid-sequence SHALL abandon the sequence with no done pulse; the first start after release SHALL behave as REQ-019.

Verification
REQ-034 seed=1, num_vec=3, ready=1 -> ye_o 0x1, 0x3, 0x6 on three consecutive cycles; f_o 0x00010000, 0x00030000, 0x00060000; zysd_o 0, 1, 2; then done=1 for one cycle and vec_cnt=3.
REQ-035 seed=0, num_vec=1, ready low for 5 cycles then high -> valid high throughout with ye_o=0x1 stable; one transfer; done follows.
REQ-036 num_vec=0, start -> done=1 on the cycle after the accepted start; valid never high; vec_cnt=0.
REQ-037 num_vec=10, abort asserted after the 4th transfer -> IDLE, valid=0, no done, vec_cnt=4; a second start during RUN is ignored.
REQ-038 rst_n dropped mid-RUN between clock edges -> all outputs 0 asynchronously; restart with seed=1 reproduces the REQ-034 sequence.
